alu_operand_collector: RTL and testbench

//  Responder end of the ALU operand stream (operand_valid/op/a/b/operand_last/ready).

---
 rtl/alu_operand_collector_if.sv | 33 +++
 rtl/alu_operand_collector.sv | 97 +++++++++
 tb/tb_alu_operand_collector.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_collector_if.sv
// Operand-beat input bus plus assembled-command output bus of the ALU operand collector.
// slave = collector side, master = operand source / ALU core side.
interface alu_operand_collector_if #(
   parameter int OPERAND_BUS_WIDTH = 8,
   parameter int MAX_BEATS         = 4
);
   localparam int OPW = OPERAND_BUS_WIDTH * MAX_BEATS;
   localparam int CW  = $clog2(MAX_BEATS + 1);

   logic                         operand_valid;
   logic [2:0]                   op;
   logic [OPERAND_BUS_WIDTH-1:0] a;
   logic [OPERAND_BUS_WIDTH-1:0] b;
   logic                         operand_last;
   logic                         ready;
   logic                         cmd_valid;
   logic                         cmd_ready;
   logic [2:0]                   cmd_op;
   logic [OPW-1:0]               cmd_a;
   logic [OPW-1:0]               cmd_b;
   logic [CW-1:0]                cmd_beats;
   logic                         cmd_overflow;

   modport master (
      output operand_valid, op, a, b, operand_last, cmd_ready,
      input  ready, cmd_valid, cmd_op, cmd_a, cmd_b, cmd_beats, cmd_overflow
   );

   modport slave (
      input  operand_valid, op, a, b, operand_last, cmd_ready,
      output ready, cmd_valid, cmd_op, cmd_a, cmd_b, cmd_beats, cmd_overflow
   );
endinterface

// File: rtl/alu_operand_collector.sv
// Packs little-endian operand beats into one ALU command; cmd_valid the cycle after the closing beat.
// ready drops while a command is held; cmd_* stay stable until cmd_ready, then ready returns next cycle.
module alu_operand_collector #(
   parameter int OPERAND_BUS_WIDTH = 8,
   parameter int MAX_BEATS         = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   alu_operand_collector_if.slave  bus
);
   localparam int OBW = OPERAND_BUS_WIDTH;
   localparam int OPW = OBW * MAX_BEATS;
   localparam int CW  = $clog2(MAX_BEATS + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_ISSUE   = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [2:0]     r_op;
   logic [OPW-1:0] r_a;
   logic [OPW-1:0] r_b;
   logic [CW-1:0]  r_beats;
   logic           r_ovf;

   logic           w_ready;
   logic           w_acc;
   logic           w_first;
   logic           w_full;
   logic           w_close;
   logic [CW-1:0]  w_cnt_nxt;
   logic [OPW-1:0] w_a_nxt;
   logic [OPW-1:0] w_b_nxt;

   assign w_ready   = rst && (r_state != S_ISSUE);
   assign w_acc     = bus.operand_valid && w_ready;
   assign w_first   = (r_state == S_IDLE);
   assign w_cnt_nxt = (w_first ? '0 : r_beats) + CW'(1);
   assign w_full    = (w_cnt_nxt == CW'(MAX_BEATS));
   assign w_close   = bus.operand_last || w_full;

   // First beat starts from zero so unreceived upper beats read back as 0.
   always_comb begin
      w_a_nxt = w_first ? '0 : r_a;
      w_b_nxt = w_first ? '0 : r_b;
      for (int k = 0; k < MAX_BEATS; k++) begin
         if (w_cnt_nxt == CW'(k + 1)) begin
            w_a_nxt[k*OBW +: OBW] = bus.a;
            w_b_nxt[k*OBW +: OBW] = bus.b;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_COLLECT: begin
            if (w_acc) w_state_nxt = w_close ? S_ISSUE : S_COLLECT;
         end
         S_ISSUE: begin
            if (bus.cmd_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_beats <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_acc) begin
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_beats <= w_cnt_nxt;
            r_ovf   <= w_full && !bus.operand_last;
            if (w_first) r_op <= bus.op;
         end
      end
   end

   assign bus.ready        = w_ready;
   assign bus.cmd_valid    = (r_state == S_ISSUE);
   assign bus.cmd_op       = r_op;
   assign bus.cmd_a        = r_a;
   assign bus.cmd_b        = r_b;
   assign bus.cmd_beats    = r_beats;
   assign bus.cmd_overflow = r_ovf;
endmodule

// File: tb/tb_alu_operand_collector.sv
// Directed bench for alu_operand_collector: packet-level model checked every cycle,
// plus hand-computed expectations for each directed scenario.
module tb_alu_operand_collector;
   localparam int OBW = 8;
   localparam int MB  = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   alu_operand_collector_if #(.OPERAND_BUS_WIDTH(OBW), .MAX_BEATS(MB)) bus ();

   alu_operand_collector #(.OPERAND_BUS_WIDTH(OBW), .MAX_BEATS(MB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Packet-level model: beats collected in queues, command formed when the packet closes.
   bit          m_issue = 1'b0;
   logic [7:0]  m_pa[$];
   logic [7:0]  m_pb[$];
   logic [2:0]  m_pop   = '0;
   logic [2:0]  m_op    = '0;
   logic [31:0] m_a     = '0;
   logic [31:0] m_b     = '0;
   int          m_beats = 0;
   bit          m_ovf   = 1'b0;

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         m_issue = 1'b0; m_pa.delete(); m_pb.delete();
         m_op = '0; m_a = '0; m_b = '0; m_beats = 0; m_ovf = 1'b0;
      end
      chk("ready", bus.ready, 64'(rst && !m_issue));
      chk("cmd_valid", bus.cmd_valid, 64'(m_issue));
      if (m_issue || !rst) begin
         chk("cmd_op", bus.cmd_op, m_op);
         chk("cmd_a", bus.cmd_a, m_a);
         chk("cmd_b", bus.cmd_b, m_b);
         chk("cmd_beats", bus.cmd_beats, 64'(m_beats));
         chk("cmd_overflow", bus.cmd_overflow, 64'(m_ovf));
      end else if (m_pa.size() == 0) begin
         chk("hold_beats", bus.cmd_beats, 64'(m_beats));
         chk("hold_overflow", bus.cmd_overflow, 64'(m_ovf));
      end
      if (rst) begin
         if (m_issue) begin
            if (bus.cmd_ready) m_issue = 1'b0;
         end else if (bus.operand_valid) begin
            if (m_pa.size() == 0) m_pop = bus.op;
            m_pa.push_back(bus.a);
            m_pb.push_back(bus.b);
            if (bus.operand_last || m_pa.size() == MB) begin
               m_issue = 1'b1;
               m_op    = m_pop;
               m_beats = m_pa.size();
               m_ovf   = !bus.operand_last;
               m_a = '0; m_b = '0;
               foreach (m_pa[k]) begin
                  m_a = m_a | (32'(m_pa[k]) << (8 * k));
                  m_b = m_b | (32'(m_pb[k]) << (8 * k));
               end
               m_pa.delete(); m_pb.delete();
            end
         end
      end
   end

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic last);
      bit acc = 1'b0;
      bus.operand_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.operand_last = last;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         acc = bus.ready;
         @(posedge clk);
         #1;
         if (acc) break;
      end
      chk("beat_accepted", 64'(acc), 64'd1);
      bus.operand_valid = 1'b0; bus.operand_last = 1'b0;
   endtask

   task automatic wait_cmd(output int waited);
      for (waited = 0; waited < 50; waited++) begin
         @(negedge clk);
         if (bus.cmd_valid === 1'b1) break;
      end
      chk("cmd_wait_bound", 64'(waited < 50), 64'd1);
   endtask

   initial begin
      #100000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      int w;
      bus.operand_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
      bus.operand_last = 1'b0; bus.cmd_ready = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_ready", bus.ready, 0);
      chk("rst_cmd_valid", bus.cmd_valid, 0);
      chk("rst_cmd_a", bus.cmd_a, 0);
      chk("rst_cmd_beats", bus.cmd_beats, 0);
      sync();
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", bus.ready, 1);
      sync();

      // 1: single-beat packet
      beat(3'b010, 8'h5A, 8'h0F, 1'b1);
      wait_cmd(w);
      chk("t1_latency", 64'(w), 0);
      chk("t1_cmd_a", bus.cmd_a, 32'h0000005A);
      chk("t1_cmd_b", bus.cmd_b, 32'h0000000F);
      chk("t1_beats", bus.cmd_beats, 1);
      chk("t1_op", bus.cmd_op, 3'b010);
      chk("t1_ready", bus.ready, 0);
      sync();

      // 2: four beats, last on the fourth
      beat(3'd4, 8'h11, 8'h01, 1'b0);
      beat(3'd4, 8'h22, 8'h02, 1'b0);
      beat(3'd4, 8'h33, 8'h03, 1'b0);
      beat(3'd4, 8'h44, 8'h04, 1'b1);
      wait_cmd(w);
      chk("t2_cmd_a", bus.cmd_a, 32'h44332211);
      chk("t2_cmd_b", bus.cmd_b, 32'h04030201);
      chk("t2_beats", bus.cmd_beats, 4);
      chk("t2_overflow", bus.cmd_overflow, 0);
      sync();

      // 3: backpressure on the command side
      bus.cmd_ready = 1'b0;
      beat(3'd7, 8'hAA, 8'h55, 1'b1);
      wait_cmd(w);
      for (int i = 0; i < 5; i++) begin
         chk("t3_stable_a", bus.cmd_a, 32'h000000AA);
         chk("t3_stable_op", bus.cmd_op, 3'd7);
         chk("t3_ready_low", bus.ready, 0);
         @(negedge clk);
      end
      sync();
      bus.cmd_ready = 1'b1;
      @(negedge clk);
      chk("t3_valid_until_hs", bus.cmd_valid, 1);
      @(negedge clk);
      chk("t3_ready_after_hs", bus.ready, 1);
      chk("t3_valid_after_hs", bus.cmd_valid, 0);
      sync();

      // 4: overflow, fifth beat stalls then starts a new packet
      bus.cmd_ready = 1'b0;
      beat(3'd3, 8'hA1, 8'hB1, 1'b0);
      beat(3'd3, 8'hA2, 8'hB2, 1'b0);
      beat(3'd3, 8'hA3, 8'hB3, 1'b0);
      beat(3'd3, 8'hA4, 8'hB4, 1'b0);
      fork
         beat(3'd5, 8'h77, 8'h88, 1'b1);
         begin
            wait_cmd(w);
            chk("t4_overflow", bus.cmd_overflow, 1);
            chk("t4_beats", bus.cmd_beats, 4);
            chk("t4_cmd_a", bus.cmd_a, 32'hA4A3A2A1);
            chk("t4_op", bus.cmd_op, 3'd3);
            repeat (3) begin
               @(negedge clk);
               chk("t4_stall_ready", bus.ready, 0);
            end
            sync();
            bus.cmd_ready = 1'b1;
         end
      join
      wait_cmd(w);
      chk("t4_next_op", bus.cmd_op, 3'd5);
      chk("t4_next_beats", bus.cmd_beats, 1);
      chk("t4_next_overflow", bus.cmd_overflow, 0);
      chk("t4_next_a", bus.cmd_a, 32'h00000077);
      sync();

      // 5: idle gaps inside a packet, op change ignored
      beat(3'd1, 8'h12, 8'h34, 1'b0);
      repeat (3) sync();
      beat(3'd6, 8'h56, 8'h78, 1'b1);
      wait_cmd(w);
      chk("t5_op", bus.cmd_op, 3'd1);
      chk("t5_cmd_a", bus.cmd_a, 32'h00005612);
      chk("t5_cmd_b", bus.cmd_b, 32'h00007834);
      sync();

      // 6: reset in the middle of a packet
      beat(3'd2, 8'h9A, 8'hCD, 1'b0);
      beat(3'd2, 8'hBC, 8'hEF, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk("t6_rst_valid", bus.cmd_valid, 0);
      chk("t6_rst_ready", bus.ready, 0);
      chk("t6_rst_cmd_a", bus.cmd_a, 0);
      sync();
      rst = 1'b1;
      beat(3'd3, 8'h01, 8'h10, 1'b0);
      beat(3'd3, 8'h02, 8'h20, 1'b1);
      wait_cmd(w);
      chk("t6_cmd_a", bus.cmd_a, 32'h00000201);
      chk("t6_cmd_b", bus.cmd_b, 32'h00002010);
      chk("t6_beats", bus.cmd_beats, 2);
      chk("t6_op", bus.cmd_op, 3'd3);
      sync();

      repeat (3) sync();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
